hdmi_rx_link_ctrl: RTL

Link supervisor for the HDMI receive path, running in the clk_10m domain. Sequences hot-plug detect and the DVI decoder reset, and measures TMDS pixel-clock activity from a divided-clock toggle. Qualifies lock by counting vsync edges and forces a re-train (HPD pulse plus decoder reset) on clock loss or vsync timeout. Sits beside the DVI decoder; drives its exrst_n and the connector HPD pin.

---
 rtl/hdmi_rx_pkg.sv | 37 +++
 rtl/hdmi_clk_meter.sv | 60 ++++++
 rtl/hdmi_rx_link_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_rx_pkg.sv
// hdmi_rx_pkg: shared definitions for the HDMI receive link supervisor.
//   - link_state_t : FSM state encoding (also driven out on the debug 'state' port)
//   - DEF_*        : default timing constants in clk_10m cycles / counts
//   - cnt_width    : counter width needed to hold 0..max_val
//   - max3         : largest of three integers, used to size a shared counter
package hdmi_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HPD_LOW   = 3'd1,
    ST_WAIT_CLK  = 3'd2,
    ST_DEC_RST   = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_LOCKED    = 3'd5,
    ST_FAULT     = 3'd6
  } link_state_t;

  localparam int DEF_HPD_LOW_CYC = 1000000;
  localparam int DEF_WIN_CYC     = 1000;
  localparam int DEF_MIN_EDGES   = 8;
  localparam int DEF_CLK_TO_WIN  = 50;
  localparam int DEF_DEC_RST_CYC = 100;
  localparam int DEF_VS_LOCK     = 2;
  localparam int DEF_VS_TO_CYC   = 1000000;
  localparam int DEF_MAX_RETRY   = 7;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hdmi_clk_meter.sv
// hdmi_clk_meter: measures TMDS pixel-clock activity from a divided-clock toggle.
// Ports:
//   clk_10m, rst_n  : control clock, asynchronous active-low reset
//   pclk_div_tgl    : toggles every 256 pclk cycles (asynchronous to clk_10m)
//   clk_edges       : toggle-edge count of the last completed window, saturating at 255
//   clk_ok          : last completed window had at least MIN_EDGES edges
//   win_end         : one-cycle pulse, high in the cycle clk_edges/clk_ok take new values
module hdmi_clk_meter
  import hdmi_rx_pkg::*;
#(
  parameter int WIN_CYC   = DEF_WIN_CYC,
  parameter int MIN_EDGES = DEF_MIN_EDGES
) (
  input  logic       clk_10m,
  input  logic       rst_n,
  input  logic       pclk_div_tgl,
  output logic [7:0] clk_edges,
  output logic       clk_ok,
  output logic       win_end
);

  localparam int WW = cnt_width(WIN_CYC - 1);

  logic [2:0]    tgl_sync;
  logic [WW-1:0] win_cnt;
  logic [7:0]    edge_cnt;
  logic          tgl_edge;
  logic          win_wrap;

  // Both toggle directions are edges; compare the last two synchroniser stages.
  assign tgl_edge = tgl_sync[2] ^ tgl_sync[1];
  assign win_wrap = (win_cnt == WW'(WIN_CYC - 1));

  always_ff @(posedge clk_10m or negedge rst_n) begin
    if (!rst_n) begin
      tgl_sync  <= 3'b000;
      win_cnt   <= '0;
      edge_cnt  <= 8'd0;
      clk_edges <= 8'd0;
      clk_ok    <= 1'b0;
      win_end   <= 1'b0;
    end else begin
      tgl_sync <= {tgl_sync[1:0], pclk_div_tgl};
      win_end  <= win_wrap;
      if (win_wrap) begin
        win_cnt   <= '0;
        clk_edges <= edge_cnt;
        clk_ok    <= (edge_cnt >= 8'(MIN_EDGES));
        // An edge arriving on the wrap cycle is the first of the new window.
        edge_cnt  <= tgl_edge ? 8'd1 : 8'd0;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        if (tgl_edge && (edge_cnt != 8'hff)) begin
          edge_cnt <= edge_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/hdmi_rx_link_ctrl.sv
// hdmi_rx_link_ctrl: HDMI receive link supervisor (clk_10m domain).
// Sequences connector HPD and the DVI decoder reset, qualifies lock on vsync
// edges and re-trains on clock loss, decoder reset or vsync timeout.
// Ports:
//   clk_10m, rst_n  : control clock, asynchronous active-low reset
//   enable          : link enable; low forces IDLE and clears fault/counters
//   pclk_div_tgl    : divided pixel-clock toggle (asynchronous)
//   rx_reset, vsync : decoder status (asynchronous)
//   hpd, dec_rst_n  : connector hot-plug detect, decoder exrst_n
//   link_up, fault  : LOCKED indicator, sticky retry-exhaustion flag
//   clk_edges       : last window edge count
//   state           : current FSM state (debug)
//   retry_cnt       : retries since last lock
// All outputs are registered from the next state, so they change together
// with 'state' in the cycle after the transition decision.
module hdmi_rx_link_ctrl
  import hdmi_rx_pkg::*;
#(
  parameter int HPD_LOW_CYC = DEF_HPD_LOW_CYC,
  parameter int WIN_CYC     = DEF_WIN_CYC,
  parameter int MIN_EDGES   = DEF_MIN_EDGES,
  parameter int CLK_TO_WIN  = DEF_CLK_TO_WIN,
  parameter int DEC_RST_CYC = DEF_DEC_RST_CYC,
  parameter int VS_LOCK     = DEF_VS_LOCK,
  parameter int VS_TO_CYC   = DEF_VS_TO_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       clk_10m,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pclk_div_tgl,
  input  logic       rx_reset,
  input  logic       vsync,
  output logic       hpd,
  output logic       dec_rst_n,
  output logic       link_up,
  output logic       fault,
  output logic [7:0] clk_edges,
  output logic [2:0] state,
  output logic [2:0] retry_cnt
);

  // One counter serves HPD hold, decoder reset hold and the vsync gap.
  localparam int CW = cnt_width(max3(HPD_LOW_CYC, DEC_RST_CYC, VS_TO_CYC));
  localparam int TW = cnt_width(CLK_TO_WIN);
  localparam int VW = cnt_width(VS_LOCK);

  logic        clk_ok;
  logic        win_end;
  logic [2:0]  rx_sync;
  logic [2:0]  vs_sync;
  logic        rx_rst_s;
  logic        vs_rise;

  link_state_t   state_q, state_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [TW-1:0] win_to_q, win_to_nx;
  logic [VW-1:0] vs_cnt_q, vs_cnt_nx;
  logic [2:0]    retry_q, retry_nx;
  logic          do_retry;

  hdmi_clk_meter #(
    .WIN_CYC   (WIN_CYC),
    .MIN_EDGES (MIN_EDGES)
  ) u_clk_meter (
    .clk_10m      (clk_10m),
    .rst_n        (rst_n),
    .pclk_div_tgl (pclk_div_tgl),
    .clk_edges    (clk_edges),
    .clk_ok       (clk_ok),
    .win_end      (win_end)
  );

  assign rx_rst_s  = rx_sync[2];
  assign vs_rise   = vs_sync[1] & ~vs_sync[2];
  assign state     = state_q;
  assign retry_cnt = retry_q;

  always_ff @(posedge clk_10m or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync   <= 3'b000;
      vs_sync   <= 3'b000;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      win_to_q  <= '0;
      vs_cnt_q  <= '0;
      retry_q   <= 3'd0;
      hpd       <= 1'b0;
      dec_rst_n <= 1'b0;
      link_up   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[1:0], rx_reset};
      vs_sync   <= {vs_sync[1:0], vsync};
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      win_to_q  <= win_to_nx;
      vs_cnt_q  <= vs_cnt_nx;
      retry_q   <= retry_nx;
      hpd       <= (state_nx inside {ST_WAIT_CLK, ST_DEC_RST, ST_WAIT_LOCK, ST_LOCKED});
      dec_rst_n <= (state_nx inside {ST_WAIT_LOCK, ST_LOCKED});
      link_up   <= (state_nx == ST_LOCKED);
      fault     <= (state_nx == ST_FAULT);
    end
  end

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    win_to_nx = win_to_q;
    vs_cnt_nx = vs_cnt_q;
    retry_nx  = retry_q;
    do_retry  = 1'b0;
    if (!enable) begin
      state_nx  = ST_IDLE;
      cnt_nx    = '0;
      win_to_nx = '0;
      vs_cnt_nx = '0;
      retry_nx  = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_nx = ST_HPD_LOW;
          cnt_nx   = '0;
        end
        ST_HPD_LOW: begin
          if (cnt_q == CW'(HPD_LOW_CYC - 1)) begin
            state_nx  = ST_WAIT_CLK;
            cnt_nx    = '0;
            win_to_nx = '0;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
        ST_WAIT_CLK: begin
          if (win_end) begin
            if (clk_ok) begin
              state_nx = ST_DEC_RST;
              cnt_nx   = '0;
            end else if (win_to_q == TW'(CLK_TO_WIN - 1)) begin
              do_retry = 1'b1;
            end else begin
              win_to_nx = win_to_q + TW'(1);
            end
          end
        end
        ST_DEC_RST: begin
          if (cnt_q == CW'(DEC_RST_CYC - 1)) begin
            state_nx  = ST_WAIT_LOCK;
            cnt_nx    = '0;
            vs_cnt_nx = '0;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // Clock loss wins; vsync edges only count while the decoder is out of reset.
          if (win_end && !clk_ok) begin
            do_retry = 1'b1;
          end else if (vs_rise && !rx_rst_s) begin
            cnt_nx = '0;
            if (vs_cnt_q == VW'(VS_LOCK - 1)) begin
              state_nx = ST_LOCKED;
              retry_nx = 3'd0;
            end else begin
              vs_cnt_nx = vs_cnt_q + VW'(1);
            end
          end else if (cnt_q == CW'(VS_TO_CYC - 1)) begin
            do_retry = 1'b1;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
        ST_LOCKED: begin
          if (win_end && !clk_ok) begin
            do_retry = 1'b1;
          end else if (rx_rst_s) begin
            do_retry = 1'b1;
          end else if (vs_rise) begin
            cnt_nx = '0;
          end else if (cnt_q == CW'(VS_TO_CYC - 1)) begin
            do_retry = 1'b1;
          end else begin
            cnt_nx = cnt_q + CW'(1);
          end
        end
        ST_FAULT: begin
          state_nx = ST_FAULT;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
      if (do_retry) begin
        cnt_nx    = '0;
        win_to_nx = '0;
        vs_cnt_nx = '0;
        if (retry_q == 3'(MAX_RETRY)) begin
          state_nx = ST_FAULT;
        end else begin
          retry_nx = retry_q + 3'd1;
          state_nx = ST_HPD_LOW;
        end
      end
    end
  end

endmodule
